// File: rtl/ram_fetch.sv
// Instruction-fetch sequencer for the program ram: owns the PC, waits out the
// ram access time, then hands the captured byte to the core via Valid/Ack.
module ram_fetch #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [7:0]  LAST_ADDR   = 8'd45
) (
    input  logic       Clock,
    input  logic       Reset,
    output logic [7:0] Address,
    input  logic [7:0] Data,
    input  logic       Fetch,
    input  logic       Branch,
    input  logic [7:0] BranchTarget,
    output logic [7:0] Instr,
    output logic       Valid,
    input  logic       Ack,
    output logic [7:0] Pc
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HOLD
    } state_e;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] instr_q, instr_d;
    logic [7:0] pc_cap_q, pc_cap_d;

    logic [7:0] branch_pc;
    logic [7:0] next_pc;

    // Out-of-range branch targets restart the program rather than running off the ram.
    assign branch_pc = (BranchTarget > LAST_ADDR) ? 8'd0 : BranchTarget;
    assign next_pc   = (pc_q == LAST_ADDR) ? 8'd0 : pc_q + 8'd1;

    always_comb begin
        // NOTE: every variable gets a default before the case, so no path can infer a latch.
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        instr_d  = instr_q;
        pc_cap_d = pc_cap_q;

        unique case (state_q)
            ST_IDLE: begin
                if (Branch) begin
                    pc_d = branch_pc;
                end else if (Fetch) begin
                    cnt_d   = WAIT_LOAD;
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (Branch) begin
                    pc_d    = branch_pc;
                    state_d = ST_IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    instr_d  = Data;
                    pc_cap_d = pc_q;
                    pc_d     = next_pc;
                    state_d  = ST_HOLD;
                end
            end

            ST_HOLD: begin
                // Branch wins over Ack/Fetch; Fetch alone is ignored until the byte is taken.
                if (Branch) begin
                    pc_d    = branch_pc;
                    state_d = ST_IDLE;
                end else if (Ack) begin
                    if (Fetch) begin
                        cnt_d   = WAIT_LOAD;
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= 8'd0;
            cnt_q    <= 4'd0;
            instr_q  <= 8'd0;
            pc_cap_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            instr_q  <= instr_d;
            pc_cap_q <= pc_cap_d;
        end
    end

    assign Address = pc_q;
    assign Instr   = instr_q;
    assign Pc      = pc_cap_q;
    assign Valid   = (state_q == ST_HOLD);

endmodule

// File: tb/tb_ram_fetch.sv
// Directed bench for ram_fetch; the ram model answers Address ^ 8'hA5.
module tb_ram_fetch;

    logic       Clock;
    logic       Reset;
    logic [7:0] Address;
    logic [7:0] Data;
    logic       Fetch;
    logic       Branch;
    logic [7:0] BranchTarget;
    logic [7:0] Instr;
    logic       Valid;
    logic       Ack;
    logic [7:0] Pc;

    int total = 0;
    int bad   = 0;

    ram_fetch #(.WAIT_CYCLES(2), .LAST_ADDR(8'd45)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Address     (Address),
        .Data        (Data),
        .Fetch       (Fetch),
        .Branch      (Branch),
        .BranchTarget(BranchTarget),
        .Instr       (Instr),
        .Valid       (Valid),
        .Ack         (Ack),
        .Pc          (Pc)
    );

    assign Data = Address ^ 8'hA5;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Fetch = 1'b0; Branch = 1'b0; BranchTarget = 8'd0; Ack = 1'b0;
        #2;
        total++; if (Valid !== 1'b0)   begin bad++; $display("FAIL reset_valid got=%0b exp=0", Valid); end
        total++; if (Address !== 8'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", Address); end
        total++; if (Instr !== 8'd0)   begin bad++; $display("FAIL reset_instr got=%h exp=00", Instr); end
        total++; if (Pc !== 8'd0)      begin bad++; $display("FAIL reset_pc got=%0d exp=0", Pc); end
        tick();
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        // Ack with nothing valid must not disturb the idle sequencer.
        Ack = 1'b1;
        tick();
        tick();
        Ack = 1'b0;
        total++; if (Valid !== 1'b0 || Address !== 8'd0) begin
            bad++; $display("FAIL idle_ack got valid=%0b addr=%0d exp valid=0 addr=0", Valid, Address);
        end
    endtask

    task automatic test_single_fetch();
        Fetch = 1'b1;
        tick();              // edge 0
        Fetch = 1'b0;
        for (int e = 1; e <= 2; e++) begin
            tick();
            total++; if (Valid !== 1'b0 || Address !== 8'd0) begin
                bad++; $display("FAIL single_wait edge=%0d valid=%0b addr=%0d exp valid=0 addr=0", e, Valid, Address);
            end
        end
        tick();              // edge 3
        total++; if (Valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b exp=1", Valid); end
        total++; if (Instr !== 8'hA5) begin bad++; $display("FAIL single_instr got=%h exp=a5", Instr); end
        total++; if (Pc !== 8'd0) begin bad++; $display("FAIL single_pc got=%0d exp=0", Pc); end
        total++; if (Address !== 8'd1) begin bad++; $display("FAIL single_addr got=%0d exp=1", Address); end
        Fetch = 1'b1;        // Fetch without Ack in HOLD is ignored
        tick();
        Fetch = 1'b0;
        total++; if (Valid !== 1'b1 || Instr !== 8'hA5) begin
            bad++; $display("FAIL hold_no_ack got valid=%0b instr=%h exp valid=1 instr=a5", Valid, Instr);
        end
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        total++; if (Valid !== 1'b0) begin bad++; $display("FAIL single_ack got=%0b exp=0", Valid); end
        tick();
        total++; if (Valid !== 1'b0 || Address !== 8'd1) begin
            bad++; $display("FAIL single_idle got valid=%0b addr=%0d exp valid=0 addr=1", Valid, Address);
        end
    endtask

    task automatic test_back_to_back();
        Branch = 1'b1; BranchTarget = 8'd0;
        tick();
        Branch = 1'b0;
        total++; if (Address !== 8'd0) begin bad++; $display("FAIL b2b_start got=%0d exp=0", Address); end
        Fetch = 1'b1; Ack = 1'b1;
        tick();              // request edge
        for (int k = 0; k < 46; k++) begin
            logic [7:0] exp_i;
            exp_i = 8'(k) ^ 8'hA5;
            tick();
            total++; if (Valid !== 1'b0) begin bad++; $display("FAIL b2b_gap k=%0d valid=%0b exp=0", k, Valid); end
            tick();
            tick();
            total++; if (Valid !== 1'b1 || Instr !== exp_i || Pc !== 8'(k)) begin
                bad++; $display("FAIL b2b_byte k=%0d got valid=%0b instr=%h pc=%0d exp valid=1 instr=%h pc=%0d",
                                k, Valid, Instr, Pc, exp_i, k);
            end
            if (k < 45) tick();   // Ack+Fetch edge restarting the next access
        end
        total++; if (Address !== 8'd0) begin bad++; $display("FAIL b2b_wrap got=%0d exp=0", Address); end
        Fetch = 1'b0;
        tick();
        Ack = 1'b0;
        total++; if (Valid !== 1'b0) begin bad++; $display("FAIL b2b_end got=%0b exp=0", Valid); end
    endtask

    task automatic test_branch_idle();
        Branch = 1'b1; BranchTarget = 8'd20;
        Fetch = 1'b1;        // Branch has priority over Fetch in IDLE
        tick();
        Branch = 1'b0; Fetch = 1'b0;
        total++; if (Address !== 8'd20) begin bad++; $display("FAIL br_idle_addr got=%0d exp=20", Address); end
        tick();
        total++; if (Valid !== 1'b0) begin bad++; $display("FAIL br_idle_nofetch got=%0b exp=0", Valid); end
        Fetch = 1'b1;
        tick();
        Fetch = 1'b0;
        tick(); tick(); tick();
        total++; if (Valid !== 1'b1 || Instr !== 8'hB1 || Pc !== 8'd20) begin
            bad++; $display("FAIL br_idle_fetch got valid=%0b instr=%h pc=%0d exp valid=1 instr=b1 pc=20", Valid, Instr, Pc);
        end
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
    endtask

    task automatic test_branch_wait();
        Fetch = 1'b1;
        tick();              // edge n: into WAIT at address 21
        Fetch = 1'b0;
        Branch = 1'b1; BranchTarget = 8'd7;
        tick();              // edge n+1
        Branch = 1'b0;
        total++; if (Address !== 8'd7) begin bad++; $display("FAIL br_wait_addr got=%0d exp=7", Address); end
        for (int e = 0; e < 4; e++) begin
            total++; if (Valid !== 1'b0) begin bad++; $display("FAIL br_wait_novalid e=%0d got=%0b exp=0", e, Valid); end
            tick();
        end
        Fetch = 1'b1;
        tick();
        Fetch = 1'b0;
        tick(); tick(); tick();
        total++; if (Valid !== 1'b1 || Instr !== 8'hA2 || Pc !== 8'd7) begin
            bad++; $display("FAIL br_wait_fetch got valid=%0b instr=%h pc=%0d exp valid=1 instr=a2 pc=7", Valid, Instr, Pc);
        end
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
    endtask

    task automatic test_branch_clamp_hold();
        Branch = 1'b1; BranchTarget = 8'd200;
        tick();
        Branch = 1'b0;
        total++; if (Address !== 8'd0) begin bad++; $display("FAIL br_clamp got=%0d exp=0", Address); end
        Fetch = 1'b1;
        tick();
        Fetch = 1'b0;
        tick(); tick(); tick();
        total++; if (Valid !== 1'b1 || Instr !== 8'hA5) begin
            bad++; $display("FAIL clamp_fetch got valid=%0b instr=%h exp valid=1 instr=a5", Valid, Instr);
        end
        Branch = 1'b1; BranchTarget = 8'd9; Ack = 1'b1; Fetch = 1'b1;
        tick();
        Branch = 1'b0; Ack = 1'b0; Fetch = 1'b0;
        total++; if (Valid !== 1'b0 || Address !== 8'd9) begin
            bad++; $display("FAIL br_hold got valid=%0b addr=%0d exp valid=0 addr=9", Valid, Address);
        end
        for (int e = 0; e < 4; e++) tick();
        total++; if (Valid !== 1'b0 || Address !== 8'd9) begin
            bad++; $display("FAIL br_hold_idle got valid=%0b addr=%0d exp valid=0 addr=9", Valid, Address);
        end
    endtask

    task automatic test_reset_mid_wait();
        Branch = 1'b1; BranchTarget = 8'd30;
        tick();
        Branch = 1'b0;
        Fetch = 1'b1;
        tick();              // edge n: counter loaded with 2
        Fetch = 1'b0;
        tick();              // edge n+1: counter now 1
        total++; if (Address !== 8'd30 || Instr !== 8'hA5) begin
            bad++; $display("FAIL rst_pre got addr=%0d instr=%h exp addr=30 instr=a5", Address, Instr);
        end
        #2;
        Reset = 1'b1;
        #1;                  // still before the next rising edge
        total++; if (Address !== 8'd0 || Valid !== 1'b0 || Instr !== 8'd0 || Pc !== 8'd0) begin
            bad++; $display("FAIL rst_async got addr=%0d valid=%0b instr=%h pc=%0d exp all zero", Address, Valid, Instr, Pc);
        end
        tick(); tick();
        @(negedge Clock);
        Reset = 1'b0;
        total++; if (Valid !== 1'b0 || Address !== 8'd0) begin
            bad++; $display("FAIL rst_nocapture got valid=%0b addr=%0d exp valid=0 addr=0", Valid, Address);
        end
        Fetch = 1'b1;
        tick();
        Fetch = 1'b0;
        tick(); tick(); tick();
        total++; if (Valid !== 1'b1 || Instr !== 8'hA5 || Pc !== 8'd0) begin
            bad++; $display("FAIL rst_refetch got valid=%0b instr=%h pc=%0d exp valid=1 instr=a5 pc=0", Valid, Instr, Pc);
        end
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_back_to_back();
        test_branch_idle();
        test_branch_wait();
        test_branch_clamp_hold();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_fetch.md
# ram_fetch

Instruction-fetch sequencer that acts as the initiator for the program ram. It holds the program counter, drives the ram `Address` port, and waits a fixed number of clocks to cover the ram access time before sampling `Data`. It then presents the byte to the core through a valid/acknowledge handshake. It sits between the core's control unit and the program ram and also handles branch redirects.

## Interface
- `WAIT_CYCLES`, default 2: clocks between the request edge and the capture edge, minus one. Covers the 500 ns access time. Legal range 0–15.
- `LAST_ADDR`, default 45: highest valid program address. The PC wraps from here to 0.
- `Clock`  in  1  system clock, rising-edge active.
- `Reset`  in  1  asynchronous, active-high reset.
- `Address`  out  8  ram address; always equals the PC register.
- `Data`  in  8  ram read data; treated as stable only at the capture edge.
- `Fetch`  in  1  core requests the next instruction (level).
- `Branch`  in  1  redirect the PC to `BranchTarget` (level, single cycle expected).
- `BranchTarget`  in  8  new PC value.
- `Instr`  out  8  captured instruction byte.
- `Valid`  out  1  `Instr` holds a fresh byte; held until acknowledged.
- `Ack`  in  1  core consumes `Instr`.
- `Pc`  out  8  address of the byte in `Instr`. Captured alongside `Instr`.

## Operation
- Reset (asynchronous, immediate): state=IDLE, PC=0, `Address`=0, `Instr`=0, `Pc`=0, `Valid`=0, wait counter=0.
- States:
  - IDLE: no access in flight.
  - WAIT: access in flight; the counter counts down.
  - HOLD: `Valid` is high; waiting for `Ack`.
- IDLE:
  - `Branch` → load PC and stay in IDLE. `Branch` has priority over `Fetch`.
  - `Fetch` → load counter with `WAIT_CYCLES` and go to WAIT.
- WAIT:
  - Counter ≠ 0 → decrement.
  - Counter = 0 → capture `Instr`←`Data` and `Pc`←PC, set `Valid`, advance PC, go to HOLD.
- PC advance: PC = (PC == `LAST_ADDR`) ? 0 : PC+1. All arithmetic is 8-bit unsigned.
- `Branch` in WAIT:
  - Abort the access: no capture, `Valid` stays 0.
  - Load PC and go to IDLE.
- HOLD:
  - `Instr`/`Pc` are stable and `Valid`=1.
  - `Ack` alone → clear `Valid`, go to IDLE.
  - `Ack` with `Fetch` → clear `Valid`, reload counter, go to WAIT. This gives back-to-back fetches.
  - `Branch` → clear `Valid`, load PC, go to IDLE. `Branch` overrides `Ack`/`Fetch` in the same cycle.
- `BranchTarget` > `LAST_ADDR` loads PC=0.
- `Fetch` without `Ack` in HOLD is ignored.
- `Ack` is ignored when `Valid`=0.

## Timing
- `Address` is registered. It changes only on the edge where the PC updates: branch, capture, or reset.
- `Address` is stable for the whole WAIT interval.
- Latency: `Fetch` sampled high at edge n in IDLE → `Valid` rises after edge n+1+`WAIT_CYCLES`. That is edge n+3 at the default setting, n+1 with `WAIT_CYCLES`=0.
- `Data` is sampled only at the capture edge.
- Back-to-back throughput: one byte per `WAIT_CYCLES`+2 clocks when `Ack` and `Fetch` are both high on the first HOLD cycle.
- Reset asserted mid-WAIT or mid-HOLD:
  - Outputs go to their reset values immediately, with no capture.
  - After release, the first access starts at address 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- The bench ram model returns `Data` = `Address` ^ 8'hA5.
- Reset, then `Fetch`=1 for one cycle at edge 0:
  - `Address`=0 throughout.
  - `Valid`=1 after edge 3 with `Instr`=8'hA5 and `Pc`=0.
  - `Address`=1 after edge 3.
  - `Ack` → `Valid`=0 next edge.
- `Fetch` and `Ack` held high for 46 consecutive fetches:
  - `Instr` sequence is 0^A5 … 45^A5, one byte every 4 clocks.
  - After the 46th capture, `Address` wraps to 0.
- `Branch`=1 with `BranchTarget`=8'd20 in IDLE → `Address`=20. The next fetch gives `Instr`=8'hB1 and `Pc`=20.
- `Branch` (target 8'd7) on edge n+1 of a WAIT started at edge n:
  - No `Valid` pulse; `Address`=7.
  - A subsequent fetch returns 8'hA2.
- `Branch` with `BranchTarget`=8'd200 → PC=0. Also, assert `Branch` together with `Ack`/`Fetch` in HOLD → `Valid` clears and state returns to IDLE.
- Assert `Reset` mid-WAIT (counter=1) → all outputs reset asynchronously, before the next clock edge. After release, the first fetch returns 8'hA5.
